systolic_sequencer: RTL and testbench

- Top-level sequencer for one tile-multiply on the NxN systolic array and its staggered A/B injection FIFOs.
- On a start pulse it performs these steps in order:
  - Loads the FIFOs and clears the PE accumulators.
  - Streams the skewed operands for the full wavefront.
  - Waits for the PE pipeline to flush.
  - Unloads the N result rows over a valid/ready handshake.
- Sits between the host/DMA command interface and systolic_control plus the PE grid.

---
 rtl/systolic_sequencer.sv | 166 ++++++++++++++++
 tb/tb_systolic_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_sequencer.sv
// systolic_sequencer
// Sequences one tile-multiply on an NxN systolic array fed by staggered
// A/B injection FIFOs: load FIFOs and clear accumulators, stream the skewed
// operand wavefront, let the PE pipeline flush, then hand the N result rows
// to a consumer over a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      single-cycle command, honoured only in IDLE
//   k_len      inner dimension (0 means N, values above N saturate to N)
//   abort      synchronous cancel, highest priority, from any state
//   load       FIFO parallel-load strobe
//   pe_clear   PE accumulator clear
//   read_en    FIFO read/shift enable
//   res_valid  a result row is presented
//   res_ready  consumer accepts the presented row
//   res_row    index of the presented row
//   res_last   high with res_valid on row N-1
//   busy       high in every state except IDLE
//   done       one-cycle completion pulse
module systolic_sequencer #(
  parameter int N      = 32,
  parameter int PE_LAT = 2,
  parameter int KW     = $clog2(N) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  input  logic                 abort,
  output logic                 load,
  output logic                 pe_clear,
  output logic                 read_en,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [$clog2(N)-1:0] res_row,
  output logic                 res_last,
  output logic                 busy,
  output logic                 done
);

  localparam int RW = $clog2(N);
  // Shared counter must hold the longest stream (3N-2 cycles) and the flush depth.
  localparam int CW = $clog2(3 * N + PE_LAT);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    FLUSH,
    DRAIN,
    DONE
  } state_t;

  state_t        r_state;
  state_t        w_stateNext;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_ek;
  logic [CW-1:0] w_ek;
  logic [RW-1:0] r_row;
  logic [31:0]   w_kExt;
  logic          w_cntZero;
  logic          w_lastRow;
  logic          w_xfer;

  // Effective inner dimension: zero and oversize requests both mean a full N.
  assign w_kExt    = 32'(k_len);
  assign w_ek      = ((w_kExt == 32'd0) || (w_kExt > 32'(N))) ? CW'(N) : CW'(w_kExt);
  assign w_cntZero = (r_cnt == '0);
  assign w_lastRow = (r_row == RW'(N - 1));
  assign w_xfer    = (r_state == DRAIN) && res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state decode; abort overrides every other transition.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (start) w_stateNext = LOAD;
      LOAD:    w_stateNext = STREAM;
      STREAM:  if (w_cntZero) w_stateNext = FLUSH;
      FLUSH:   if (w_cntZero) w_stateNext = DRAIN;
      DRAIN:   if (w_xfer && w_lastRow) w_stateNext = DONE;
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
    if (abort) begin
      w_stateNext = IDLE;
    end
  end

  // One down-counter serves both STREAM (loaded with S-1 in LOAD, where
  // S = ek + 2(N-1) covers the skewed wavefront) and FLUSH (loaded with
  // PE_LAT-1 on the last stream cycle). The row index advances on each
  // accepted transfer and is cleared again when the last row leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_ek  <= '0;
      r_row <= '0;
    end else if (abort) begin
      r_cnt <= '0;
      r_ek  <= '0;
      r_row <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          r_row <= '0;
          if (start) r_ek <= w_ek;
        end
        LOAD: r_cnt <= r_ek + CW'(2 * N - 3);
        STREAM: begin
          if (w_cntZero) r_cnt <= CW'(PE_LAT - 1);
          else           r_cnt <= r_cnt - 1'b1;
        end
        FLUSH: begin
          if (!w_cntZero) r_cnt <= r_cnt - 1'b1;
        end
        DRAIN: begin
          if (w_xfer) begin
            if (w_lastRow) r_row <= '0;
            else           r_row <= r_row + 1'b1;
          end
        end
        default: begin
          r_cnt <= '0;
          r_row <= '0;
        end
      endcase
    end
  end

  // Moore output decode from registered state and row counter only.
  always_comb begin
    load      = 1'b0;
    pe_clear  = 1'b0;
    read_en   = 1'b0;
    res_valid = 1'b0;
    res_last  = 1'b0;
    done      = 1'b0;
    busy      = (r_state != IDLE);
    res_row   = r_row;
    case (r_state)
      LOAD: begin
        load     = 1'b1;
        pe_clear = 1'b1;
      end
      STREAM: read_en = 1'b1;
      DRAIN: begin
        res_valid = 1'b1;
        res_last  = w_lastRow;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_systolic_sequencer.sv
// tb_systolic_sequencer
// Directed self-checking bench for systolic_sequencer with N=32, PE_LAT=2.
module tb_systolic_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] k_len;
  logic       abort;
  logic       load;
  logic       pe_clear;
  logic       read_en;
  logic       res_valid;
  logic       res_ready;
  logic [4:0] res_row;
  logic       res_last;
  logic       busy;
  logic       done;

  int assertCount = 0;
  int failCount   = 0;

  // Per-sequence observations gathered by applyStimulus
  int rdCnt, ldCnt, clrCnt, bsyCnt, fvC, dnC, rowErr, rowXfer;
  bit timedOut;
  bit sawDone;

  systolic_sequencer #(.N(32), .PE_LAT(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .k_len    (k_len),
    .abort    (abort),
    .load     (load),
    .pe_clear (pe_clear),
    .read_en  (read_en),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_row  (res_row),
    .res_last (res_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Called at a falling edge: pulses start, then follows one full sequence
  // cycle by cycle (c=1 is the LOAD cycle) until done, returning at the
  // falling edge of the cycle after done.
  task automatic applyStimulus(input logic [5:0] kLen, input bit backPressure, input bit injectStart);
    int c;
    int expRow;
    int drainC;
    bit fin;
    rdCnt = 0; ldCnt = 0; clrCnt = 0; bsyCnt = 0; rowErr = 0; rowXfer = 0;
    fvC = -1; dnC = -1; timedOut = 0;
    expRow = 0; drainC = 0; fin = 0;
    res_ready = backPressure ? 1'b0 : 1'b1;
    start = 1'b1;
    k_len = kLen;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    while (!fin) begin
      if (c > 2000) begin
        timedOut = 1;
        break;
      end
      if (load)     ldCnt++;
      if (pe_clear) clrCnt++;
      if (read_en)  rdCnt++;
      if (busy)     bsyCnt++;
      if (res_valid) begin
        if (fvC < 0) fvC = c;
        if ((res_row !== 5'(expRow)) || (res_last !== (expRow == 31))) rowErr++;
        res_ready = backPressure ? ((drainC % 3) == 2) : 1'b1;
        if (res_ready) begin
          expRow++;
          rowXfer++;
        end
        drainC++;
      end else begin
        res_ready = backPressure ? 1'b0 : 1'b1;
        if ((fvC >= 0) && !done) rowErr++;
      end
      if (done) begin
        dnC = c;
        fin = 1;
      end
      if (injectStart && ((c == 10) || done)) start = 1'b1;
      else                                    start = 1'b0;
      @(negedge clk);
      c++;
    end
    start = 1'b0;
  endtask

  task automatic checkRun(input string tag, input int expRead, input int expFirstValid, input int expDone);
    checkOutput({tag, " timeout"}, 32'(timedOut), 0);
    checkOutput({tag, " load cycles"}, ldCnt, 1);
    checkOutput({tag, " pe_clear cycles"}, clrCnt, 1);
    checkOutput({tag, " read_en cycles"}, rdCnt, expRead);
    checkOutput({tag, " first res_valid cycle"}, fvC, expFirstValid);
    checkOutput({tag, " done cycle"}, dnC, expDone);
    checkOutput({tag, " busy cycles"}, bsyCnt, expDone);
    checkOutput({tag, " row errors"}, rowErr, 0);
    checkOutput({tag, " rows transferred"}, rowXfer, 32);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b0; k_len = '0;
    #12;
    checkOutput("reset outputs", {load, pe_clear, read_en, res_valid, res_last, busy, done}, 0);
    checkOutput("reset res_row", res_row, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle busy", busy, 0);

    // Asynchronous reset in the middle of STREAM
    start = 1'b1; k_len = 6'd32;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("mid-stream read_en", read_en, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset outputs", {load, pe_clear, read_en, res_valid, res_last, busy, done}, 0);
    checkOutput("async reset res_row", res_row, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Nominal k_len=32: S=94, first valid at 2+94+2, done at 3+94+2+31
    applyStimulus(6'd32, 0, 0);
    checkRun("nominal", 94, 98, 130);
    checkOutput("nominal done one cycle", done, 0);
    checkOutput("nominal busy after done", busy, 0);
    @(negedge clk);

    applyStimulus(6'd0, 0, 0);
    checkRun("k_len=0", 94, 98, 130);
    @(negedge clk);

    // k_len=5: S=5+62=67
    applyStimulus(6'd5, 0, 0);
    checkRun("k_len=5", 67, 71, 103);
    @(negedge clk);

    applyStimulus(6'd40, 0, 0);
    checkRun("k_len=40", 94, 98, 130);
    @(negedge clk);

    // 1-on/2-off ready: each row held 3 cycles, drain spans 96 cycles
    applyStimulus(6'd32, 1, 0);
    checkRun("backpressure", 94, 98, 194);
    @(negedge clk);

    // start during STREAM and during DONE is ignored
    applyStimulus(6'd32, 0, 1);
    checkRun("ignored starts", 94, 98, 130);
    checkOutput("start in DONE ignored", busy, 0);
    @(negedge clk);
    checkOutput("no second sequence", {load, busy}, 0);
    @(negedge clk);

    // Back-to-back: second start on the cycle after done
    applyStimulus(6'd32, 0, 0);
    applyStimulus(6'd32, 0, 0);
    checkRun("back-to-back", 94, 98, 130);
    @(negedge clk);

    // Abort during FLUSH (STREAM occupies cycles 2..95, FLUSH 96..97)
    start = 1'b1; k_len = 6'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (95) @(negedge clk);
    checkOutput("in flush", {read_en, busy, res_valid}, 3'b010);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort to idle", busy, 0);
    sawDone = 0;
    for (int i = 0; i < 4; i++) begin
      if (done || res_valid || busy) sawDone = 1;
      @(negedge clk);
    end
    checkOutput("abort no done", 32'(sawDone), 0);

    // abort and start together in IDLE
    start = 1'b1; abort = 1'b1; k_len = 6'd32;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checkOutput("abort+start stays idle", {load, busy}, 0);
    @(negedge clk);
    checkOutput("abort+start still idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
